// File: rtl/wfg_drive_spi_core_if.sv
// Stream handshake carrying stimulus samples from the pattern stage into the SPI drive stage.
interface wfg_drive_spi_core_if #(
  parameter int DW = 32
);
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;

  modport master (output s_tvalid, output s_tdata, input s_tready);
  modport slave  (input s_tvalid, input s_tdata, output s_tready);
endinterface

// File: rtl/wfg_drive_spi_core.sv
// SPI master drive stage (CPHA=0): serialises one stream sample per handshake onto sclk/cs/sdo
// and assembles sdi into a right-aligned receive word.
module wfg_drive_spi_core #(
  parameter int DW   = 32,
  parameter int DIVW = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_cpol_i,
  input  logic                 cfg_cspol_i,
  input  logic                 cfg_lsbfirst_i,
  input  logic [1:0]           cfg_sz_i,
  input  logic [DIVW-1:0]      cfg_clkdiv_i,
  wfg_drive_spi_core_if.slave  s_axis,
  output logic                 spi_sclk_o,
  output logic                 spi_cs_o,
  output logic                 spi_sdo_o,
  input  logic                 spi_sdi_i,
  output logic [DW-1:0]        rx_data_o,
  output logic                 rx_valid_o
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t          state;
  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] div_q;
  logic [5:0]      hp;
  logic [4:0]      bit_idx;
  logic [1:0]      sz_q;
  logic            cpol_q;
  logic            cspol_q;
  logic            lsb_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   rx_sh;

  logic            hs;
  logic            tick;
  logic [5:0]      last_hp;
  logic [4:0]      first_idx;
  logic [4:0]      next_idx;

  assign s_axis.s_tready = (state == IDLE) && cfg_en_i && !wb_rst_i;
  assign hs        = s_axis.s_tvalid && s_axis.s_tready;
  assign tick      = (cnt == div_q);
  // {sz,4'hF} == 2*nbits-1, the index of the final half-period in SHIFT
  assign last_hp   = {sz_q, 4'hF};
  assign first_idx = cfg_lsbfirst_i ? 5'd0 : {cfg_sz_i, 3'b111};
  assign next_idx  = lsb_q ? bit_idx + 5'd1 : bit_idx - 5'd1;

  always_ff @(posedge wb_clk_i) begin
    rx_valid_o <= 1'b0;
    if (wb_rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      hp         <= '0;
      bit_idx    <= '0;
      spi_sclk_o <= cfg_cpol_i;
      spi_cs_o   <= ~cfg_cspol_i;
      spi_sdo_o  <= 1'b0;
      rx_data_o  <= '0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + DIVW'(1);
      unique case (state)
        IDLE: begin
          // Idle levels follow live config until a word latches its own copy
          spi_sclk_o <= cfg_cpol_i;
          spi_cs_o   <= ~cfg_cspol_i;
          spi_sdo_o  <= 1'b0;
          if (hs) begin
            data_q    <= s_axis.s_tdata;
            rx_sh     <= '0;
            sz_q      <= cfg_sz_i;
            div_q     <= cfg_clkdiv_i;
            cpol_q    <= cfg_cpol_i;
            cspol_q   <= cfg_cspol_i;
            lsb_q     <= cfg_lsbfirst_i;
            bit_idx   <= first_idx;
            spi_cs_o  <= cfg_cspol_i;
            spi_sdo_o <= s_axis.s_tdata[first_idx];
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            spi_sclk_o     <= ~cpol_q;
            rx_sh[bit_idx] <= spi_sdi_i;
            hp             <= '0;
            state          <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            hp <= hp + 6'd1;
            if (hp == last_hp) begin
              state <= HOLD;
            end else if (!hp[0]) begin
              spi_sclk_o <= cpol_q;
              if (hp != last_hp - 6'd1) begin
                bit_idx   <= next_idx;
                spi_sdo_o <= data_q[next_idx];
              end
            end else begin
              spi_sclk_o     <= ~cpol_q;
              rx_sh[bit_idx] <= spi_sdi_i;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            rx_data_o  <= rx_sh;
            rx_valid_o <= 1'b1;
            spi_cs_o   <= ~cspol_q;
            spi_sdo_o  <= 1'b0;
            state      <= GAP;
          end
        end
        GAP: begin
          if (tick) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wfg_drive_spi_core.sv
// Directed bench for wfg_drive_spi_core with sdo looped back to sdi.
module tb_wfg_drive_spi_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b1;
  logic        cfg_cpol = 1'b0;
  logic        cfg_cspol = 1'b0;
  logic        cfg_lsb = 1'b0;
  logic [1:0]  cfg_sz = 2'd0;
  logic [7:0]  cfg_div = 8'd1;
  logic        sclk, cs, sdo, sdi;
  logic [31:0] rx_data;
  logic        rx_valid;

  wfg_drive_spi_core_if #(.DW(32)) s_if ();

  assign sdi = sdo;

  wfg_drive_spi_core #(.DW(32), .DIVW(8)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .cfg_en_i       (cfg_en),
    .cfg_cpol_i     (cfg_cpol),
    .cfg_cspol_i    (cfg_cspol),
    .cfg_lsbfirst_i (cfg_lsb),
    .cfg_sz_i       (cfg_sz),
    .cfg_clkdiv_i   (cfg_div),
    .s_axis         (s_if),
    .spi_sclk_o     (sclk),
    .spi_cs_o       (cs),
    .spi_sdo_o      (sdo),
    .spi_sdi_i      (sdi),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expectations the monitor needs, written only by the test tasks
  int   exp_pw = 2;
  logic cur_cpol = 1'b0;
  logic cur_cspol = 1'b0;

  // monitor state, written only by the monitor processes
  int          cyc = 0;
  int          lead_cnt = 0;
  int          pw_bad = 0;
  int          cs_bad = 0;
  int          rxv_cnt = 0;
  int          hs_n = 0;
  int          run = 0;
  int          gap_run = 0;
  int          last_gap = 0;
  int          hs_t [16];
  logic [31:0] rx_hist [16];
  logic [63:0] bits_cap = '0;
  logic        sclk_prev = 1'b0;
  logic        cs_prev = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sclk !== sclk_prev) begin
      if (sclk === ~cur_cpol) begin
        lead_cnt++;
        bits_cap = {bits_cap[62:0], sdo};
        if (cs !== cur_cspol) cs_bad++;
        run = 1;
      end else if (run != exp_pw) begin
        pw_bad++;
      end
    end else begin
      run++;
    end
    sclk_prev = sclk;
    if (cs === cur_cspol) begin
      if (cs_prev !== cur_cspol) last_gap = gap_run;
    end else begin
      gap_run = (cs_prev === cur_cspol) ? 1 : gap_run + 1;
    end
    cs_prev = cs;
    if (rx_valid === 1'b1) begin
      rx_hist[rxv_cnt % 16] = rx_data;
      rxv_cnt++;
    end
    if (s_if.s_tvalid === 1'b1 && s_if.s_tready === 1'b1) begin
      hs_t[hs_n % 16] = cyc;
      hs_n++;
    end
  end

  task automatic tick_n();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    while (hs_n < target && t < 300) begin
      tick_n();
      t++;
    end
    if (hs_n < target) begin
      checks++; errors++;
      $display("FAIL hs_timeout got %0d handshakes want %0d", hs_n, target);
    end
  endtask

  task automatic wait_rx(input int target);
    int t = 0;
    while (rxv_cnt < target && t < 3000) begin
      tick_n();
      t++;
    end
    if (rxv_cnt < target) begin
      checks++; errors++;
      $display("FAIL rx_timeout got %0d rx_valid pulses want %0d", rxv_cnt, target);
    end
  endtask

  task automatic start_word(input logic [31:0] d);
    int h0;
    h0 = hs_n;
    @(posedge clk); #1;
    s_if.s_tvalid = 1'b1;
    s_if.s_tdata  = d;
    wait_hs(h0 + 1);
    @(posedge clk); #1;
    s_if.s_tvalid = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] sz, input logic [7:0] dv, input logic cp,
                         input logic csp, input logic lsb);
    @(posedge clk); #1;
    cfg_sz = sz; cfg_div = dv; cfg_cpol = cp; cfg_cspol = csp; cfg_lsb = lsb;
    cur_cpol = cp; cur_cspol = csp; exp_pw = int'(dv) + 1;
    repeat (3) tick_n();
  endtask

  task automatic test_reset();
    int l0, r0;
    repeat (3) tick_n();
    checks++; if (s_if.s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", s_if.s_tready); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b want 0", sclk); end
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rst_cs got %b want 1", cs); end
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL rst_sdo got %b want 0", sdo); end
    checks++; if ({rx_valid, rx_data} !== 33'd0) begin errors++; $display("FAIL rst_rx got %b/%h want 0/0", rx_valid, rx_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick_n();
    checks++; if (s_if.s_tready !== 1'b1) begin errors++; $display("FAIL idle_tready got %b want 1", s_if.s_tready); end
    // abort an 8'hFF word while sclk is high in its third pulse
    set_cfg(2'd0, 8'd3, 1'b0, 1'b0, 1'b0);
    l0 = lead_cnt; r0 = rxv_cnt;
    start_word(32'h000000FF);
    while (lead_cnt < l0 + 3 && rxv_cnt == r0) tick_n();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL midrst_cs got %b want 1", cs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL midrst_sclk got %b want 0", sclk); end
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL midrst_sdo got %b want 0", sdo); end
    rst = 1'b0;
    repeat (80) tick_n();
    checks++; if (rxv_cnt - r0 !== 0) begin errors++; $display("FAIL midrst_rxvalid got %0d pulses want 0", rxv_cnt - r0); end
    checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL midrst_rxdata got %h want 00000000", rx_data); end
  endtask

  task automatic test_msb8();
    int l0, p0, c0, r0;
    set_cfg(2'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    l0 = lead_cnt; p0 = pw_bad; c0 = cs_bad; r0 = rxv_cnt;
    start_word(32'hFFFFFFA5);
    wait_rx(r0 + 1);
    repeat (4) tick_n();
    checks++; if (bits_cap[7:0] !== 8'hA5) begin errors++; $display("FAIL msb8_bits got %h want a5", bits_cap[7:0]); end
    checks++; if (lead_cnt - l0 !== 8) begin errors++; $display("FAIL msb8_pulses got %0d want 8", lead_cnt - l0); end
    checks++; if (pw_bad - p0 !== 0) begin errors++; $display("FAIL msb8_pulsewidth got %0d bad want 0", pw_bad - p0); end
    checks++; if (cs_bad - c0 !== 0) begin errors++; $display("FAIL msb8_cs got %0d bad want 0", cs_bad - c0); end
    checks++; if (rx_data !== 32'h000000A5) begin errors++; $display("FAIL msb8_rx got %h want 000000a5", rx_data); end
    checks++; if (rxv_cnt - r0 !== 1) begin errors++; $display("FAIL msb8_rxvalid got %0d want 1", rxv_cnt - r0); end
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL msb8_cs_idle got %b want 1", cs); end
  endtask

  task automatic test_lsb32();
    int l0, p0, c0, r0;
    set_cfg(2'd3, 8'd1, 1'b1, 1'b1, 1'b1);
    l0 = lead_cnt; p0 = pw_bad; c0 = cs_bad; r0 = rxv_cnt;
    start_word(32'h80000001);
    wait_rx(r0 + 1);
    repeat (4) tick_n();
    checks++; if (bits_cap[31:0] !== 32'h80000001) begin errors++; $display("FAIL lsb32_bits got %h want 80000001", bits_cap[31:0]); end
    checks++; if (lead_cnt - l0 !== 32) begin errors++; $display("FAIL lsb32_pulses got %0d want 32", lead_cnt - l0); end
    checks++; if (pw_bad - p0 !== 0 || cs_bad - c0 !== 0) begin errors++; $display("FAIL lsb32_shape got pw %0d cs %0d bad want 0 0", pw_bad - p0, cs_bad - c0); end
    checks++; if (rx_data !== 32'h80000001) begin errors++; $display("FAIL lsb32_rx got %h want 80000001", rx_data); end
    checks++; if ({sclk, cs} !== 2'b10) begin errors++; $display("FAIL lsb32_idle got sclk %b cs %b want 1 0", sclk, cs); end
    set_cfg(2'd1, 8'd1, 1'b1, 1'b1, 1'b1);
    r0 = rxv_cnt;
    start_word(32'h000000F1);
    wait_rx(r0 + 1);
    checks++; if (bits_cap[15:0] !== 16'h8F00) begin errors++; $display("FAIL lsb16_order got %h want 8f00", bits_cap[15:0]); end
    checks++; if (rx_data !== 32'h000000F1) begin errors++; $display("FAIL lsb16_rx got %h want 000000f1", rx_data); end
  endtask

  task automatic test_back_to_back();
    int l0, h0, r0;
    set_cfg(2'd1, 8'd0, 1'b0, 1'b0, 1'b0);
    l0 = lead_cnt; h0 = hs_n; r0 = rxv_cnt;
    @(posedge clk); #1;
    s_if.s_tvalid = 1'b1;
    s_if.s_tdata  = 32'h00001234;
    wait_hs(h0 + 1);
    @(posedge clk); #1;
    s_if.s_tdata = 32'h00005678;
    wait_hs(h0 + 2);
    @(posedge clk); #1;
    s_if.s_tvalid = 1'b0;
    wait_rx(r0 + 2);
    checks++; if (hs_t[(h0 + 1) % 16] - hs_t[h0 % 16] !== 36) begin errors++; $display("FAIL b2b_period got %0d want 36", hs_t[(h0 + 1) % 16] - hs_t[h0 % 16]); end
    checks++; if (rx_hist[r0 % 16] !== 32'h00001234) begin errors++; $display("FAIL b2b_rx0 got %h want 00001234", rx_hist[r0 % 16]); end
    checks++; if (rx_hist[(r0 + 1) % 16] !== 32'h00005678) begin errors++; $display("FAIL b2b_rx1 got %h want 00005678", rx_hist[(r0 + 1) % 16]); end
    checks++; if (bits_cap[31:0] !== 32'h12345678) begin errors++; $display("FAIL b2b_bits got %h want 12345678", bits_cap[31:0]); end
    checks++; if (lead_cnt - l0 !== 32) begin errors++; $display("FAIL b2b_pulses got %0d want 32", lead_cnt - l0); end
    checks++; if (last_gap !== 2) begin errors++; $display("FAIL b2b_cs_gap got %0d want 2", last_gap); end
  endtask

  task automatic test_enable_drop();
    int l0, h0, r0, rdy;
    set_cfg(2'd1, 8'd1, 1'b0, 1'b0, 1'b0);
    l0 = lead_cnt; h0 = hs_n; r0 = rxv_cnt; rdy = 0;
    @(posedge clk); #1;
    s_if.s_tvalid = 1'b1;
    s_if.s_tdata  = 32'h0000BEEF;
    wait_hs(h0 + 1);
    while (lead_cnt < l0 + 4 && rxv_cnt == r0) tick_n();
    @(posedge clk); #1;
    cfg_en = 1'b0;
    wait_rx(r0 + 1);
    for (int i = 0; i < 30; i++) begin
      tick_n();
      if (s_if.s_tready !== 1'b0) rdy++;
    end
    checks++; if (rx_data !== 32'h0000BEEF) begin errors++; $display("FAIL endrop_rx got %h want 0000beef", rx_data); end
    checks++; if (lead_cnt - l0 !== 16) begin errors++; $display("FAIL endrop_pulses got %0d want 16", lead_cnt - l0); end
    checks++; if (rdy !== 0) begin errors++; $display("FAIL endrop_tready got %0d ready cycles want 0", rdy); end
    checks++; if (hs_n - h0 !== 1) begin errors++; $display("FAIL endrop_handshakes got %0d want 1", hs_n - h0); end
    @(posedge clk); #1;
    s_if.s_tvalid = 1'b0;
    cfg_en = 1'b1;
  endtask

  task automatic test_cfg_change();
    int l0, p0, r0;
    set_cfg(2'd1, 8'd1, 1'b0, 1'b0, 1'b0);
    l0 = lead_cnt; p0 = pw_bad; r0 = rxv_cnt;
    start_word(32'h0000C3A5);
    cfg_sz  = 2'd0;
    cfg_div = 8'd3;
    wait_rx(r0 + 1);
    checks++; if (lead_cnt - l0 !== 16) begin errors++; $display("FAIL cfgchg_pulses got %0d want 16", lead_cnt - l0); end
    checks++; if (pw_bad - p0 !== 0) begin errors++; $display("FAIL cfgchg_pulsewidth got %0d bad want 0", pw_bad - p0); end
    checks++; if (rx_data !== 32'h0000C3A5) begin errors++; $display("FAIL cfgchg_rx got %h want 0000c3a5", rx_data); end
    repeat (3) tick_n();
    exp_pw = 4;
    l0 = lead_cnt; p0 = pw_bad; r0 = rxv_cnt;
    start_word(32'h0000003C);
    wait_rx(r0 + 1);
    checks++; if (lead_cnt - l0 !== 8) begin errors++; $display("FAIL cfgnew_pulses got %0d want 8", lead_cnt - l0); end
    checks++; if (pw_bad - p0 !== 0) begin errors++; $display("FAIL cfgnew_pulsewidth got %0d bad want 0", pw_bad - p0); end
    checks++; if (bits_cap[7:0] !== 8'h3C) begin errors++; $display("FAIL cfgnew_bits got %h want 3c", bits_cap[7:0]); end
    checks++; if (rx_data !== 32'h0000003C) begin errors++; $display("FAIL cfgnew_rx got %h want 0000003c", rx_data); end
  endtask

  initial begin
    s_if.s_tvalid = 1'b0;
    s_if.s_tdata  = '0;
    test_reset();
    test_msb8();
    test_lsb32();
    test_back_to_back();
    test_enable_drop();
    test_cfg_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
